// File: rtl/rr_port_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin port arbiter:
// state encoding, requester count, select and tenure widths.
package rr_port_arbiter4_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;
  localparam int TEN_W = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NREQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    return NREQ'(1) << sel;
  endfunction

endpackage

// File: rtl/rr_port_arbiter4_if.sv
// Requester-side bundle of the shared port: request levels, the four
// requester words, and the registered grant / select / data returned.
interface rr_port_arbiter4_if #(
  parameter int Nbit = 12
);
  import rr_port_arbiter4_pkg::*;

  logic [NREQ-1:0]  req;
  logic [Nbit-1:0]  data1;
  logic [Nbit-1:0]  data2;
  logic [Nbit-1:0]  data3;
  logic [Nbit-1:0]  data4;
  logic [NREQ-1:0]  gnt;
  logic [SEL_W-1:0] mux_sel;
  logic             busy;
  logic [Nbit-1:0]  Data_out;

  modport master (
    output req, data1, data2, data3, data4,
    input  gnt, mux_sel, busy, Data_out
  );

  modport slave (
    input  req, data1, data2, data3, data4,
    output gnt, mux_sel, busy, Data_out
  );

endinterface

// File: rtl/rr_port_arbiter4_mux.sv
// mux4to1: plain 4:1 word multiplexer driving the shared-port data.
module mux4to1 #(
  parameter int Nbit = 12
) (
  input  logic [1:0]      sel,
  input  logic [Nbit-1:0] d0,
  input  logic [Nbit-1:0] d1,
  input  logic [Nbit-1:0] d2,
  input  logic [Nbit-1:0] d3,
  output logic [Nbit-1:0] y
);

  // Select the word of the indexed requester.
  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_port_arbiter4_pick.sv
// rr_pick4: combinational round-robin search. Scans last+1, last+2,
// last+3, last (mod 4) and reports the first requester found.
module rr_pick4
  import rr_port_arbiter4_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] winner
);

  // Search from the farthest position inward so the nearest requester after last wins.
  always_comb begin
    any    = |req;
    winner = last;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[last + SEL_W'(k)]) winner = last + SEL_W'(k);
    end
  end

endmodule

// File: rtl/rr_port_arbiter4.sv
// rr_port_arbiter4: round-robin arbiter for one shared Nbit port among
// four requesters. Registered one-hot grant, registered mux select,
// combinational data return. Optional macro ARB_TIMEOUT_EN limits an
// owner to MAX_HOLD consecutive cycles while another requester waits.
module rr_port_arbiter4
  import rr_port_arbiter4_pkg::*;
#(
  parameter int Nbit     = 12,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  rr_port_arbiter4_if.slave  bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_port_arbiter4: MAX_HOLD must be within 2..255");
  end

  arb_state_t       state_p1, state_p0;
  logic [NREQ-1:0]  gnt_p1,   gnt_p0;
  logic [SEL_W-1:0] sel_p1,   sel_p0;
  logic [SEL_W-1:0] last_p1,  last_p0;
  logic             any;
  logic [SEL_W-1:0] winner;
  logic             owner_held;
  logic             do_grant;
  logic [NREQ-1:0]  cand;
`ifdef ARB_TIMEOUT_EN
  logic [TEN_W-1:0] tenure_p1, tenure_p0;
`endif

  // The current owner is masked out so a handover or forced rotation
  // always lands on a different requester; in IDLE gnt is zero.
  assign cand = bus.req & ~gnt_p1;

  rr_pick4 u_pick (
    .req    (cand),
    .last   (last_p1),
    .any    (any),
    .winner (winner)
  );

  // Next grant, select, pointer and tenure from the sampled requests.
  always_comb begin
    state_p0   = state_p1;
    gnt_p0     = gnt_p1;
    sel_p0     = sel_p1;
    last_p0    = last_p1;
    do_grant   = 1'b0;
    owner_held = |(bus.req & gnt_p1);
`ifdef ARB_TIMEOUT_EN
    tenure_p0  = tenure_p1;
`endif
    case (state_p1)
      ARB_IDLE: begin
        if (any) do_grant = 1'b1;
      end
      ARB_OWNED: begin
        if (owner_held) begin
`ifdef ARB_TIMEOUT_EN
          if (tenure_p1 == TEN_W'(MAX_HOLD - 1) && any) begin
            do_grant = 1'b1;
          end else if (tenure_p1 != {TEN_W{1'b1}}) begin
            tenure_p0 = tenure_p1 + TEN_W'(1);
          end
`endif
        end else if (any) begin
          do_grant = 1'b1;
        end else begin
          state_p0 = ARB_IDLE;
          gnt_p0   = '0;
        end
      end
      default: begin
        state_p0 = ARB_IDLE;
        gnt_p0   = '0;
      end
    endcase
    if (do_grant) begin
      state_p0 = ARB_OWNED;
      gnt_p0   = sel_to_onehot(winner);
      sel_p0   = winner;
      last_p0  = winner;
`ifdef ARB_TIMEOUT_EN
      tenure_p0 = '0;
`endif
    end
  end

  // Arbitration state register; pointer resets to 3 so requester 0 leads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= ARB_IDLE;
      gnt_p1   <= '0;
      sel_p1   <= '0;
      last_p1  <= SEL_W'(NREQ - 1);
`ifdef ARB_TIMEOUT_EN
      tenure_p1 <= '0;
`endif
    end else begin
      state_p1 <= state_p0;
      gnt_p1   <= gnt_p0;
      sel_p1   <= sel_p0;
      last_p1  <= last_p0;
`ifdef ARB_TIMEOUT_EN
      tenure_p1 <= tenure_p0;
`endif
    end
  end

  mux4to1 #(.Nbit(Nbit)) u_mux (
    .sel (sel_p1),
    .d0  (bus.data1),
    .d1  (bus.data2),
    .d2  (bus.data3),
    .d3  (bus.data4),
    .y   (bus.Data_out)
  );

  assign bus.gnt     = gnt_p1;
  assign bus.mux_sel = sel_p1;
  assign bus.busy    = |gnt_p1;

endmodule

// File: tb/tb_rr_port_arbiter4.sv
// Bench for rr_port_arbiter4: directed scenarios plus random requests,
// predicted by a behavioural model and checked by a scoreboard monitor.
module tb_rr_port_arbiter4;

  localparam int NB = 12;
  localparam int MH = 8;

  typedef struct {
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          busy;
    logic [NB-1:0] dout;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_port_arbiter4_if #(.Nbit(NB)) bus ();

  rr_port_arbiter4 #(.Nbit(NB), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            m_owner = -1;
  int            m_last  = 3;
  int            m_sel   = 0;
  int            m_hold  = 0;
  logic [NB-1:0] dv[4];
  bit            keep_data = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester set, scanning after 'last' in circular order.
  function automatic int rr_next(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // Advance the reference model by one rising edge.
  task automatic model_edge(input logic [3:0] r, input bit rs);
    int w;
    logic [3:0] oth;
    if (rs) begin
      m_owner = -1; m_last = 3; m_sel = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      w = rr_next(r, m_last);
      if (w >= 0) begin m_owner = w; m_last = w; m_sel = w; m_hold = 0; end
    end else if (r[m_owner]) begin
      oth = r;
      oth[m_owner] = 1'b0;
`ifdef ARB_TIMEOUT_EN
      if (m_hold == MH - 1 && oth != 4'b0) begin
        w = rr_next(oth, m_owner);
        m_owner = w; m_last = w; m_sel = w; m_hold = 0;
      end else if (m_hold < 255) m_hold++;
`else
      if (m_hold < 255) m_hold++;
`endif
    end else begin
      w = rr_next(r, m_owner);
      if (w >= 0) begin m_owner = w; m_last = w; m_sel = w; m_hold = 0; end
      else m_owner = -1;
    end
  endtask

  task automatic step(input logic [3:0] r, input bit rs);
    exp_t e;
    @(negedge clk);
    reset   = rs;
    bus.req = r;
    if (!keep_data) for (int i = 0; i < 4; i++) dv[i] = NB'($urandom);
    bus.data1 = dv[0];
    bus.data2 = dv[1];
    bus.data3 = dv[2];
    bus.data4 = dv[3];
    if (rs) begin
      #1;
      check("async_reset_gnt", bus.gnt, 0);
      check("async_reset_sel", bus.mux_sel, 0);
    end
    model_edge(r, rs);
    e.gnt = 4'b0;
    if (m_owner >= 0) e.gnt[m_owner] = 1'b1;
    e.sel  = 2'(m_sel);
    e.busy = (m_owner >= 0);
    e.dout = dv[m_sel];
    sb.push_back(e);
  endtask

  // Monitor: pop the prediction for each edge and check protocol invariants.
  initial begin
    exp_t e;
    logic [3:0] prev_gnt;
    int waitc[4];
    prev_gnt = 4'b0;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("gnt", bus.gnt, e.gnt);
        check("mux_sel", bus.mux_sel, e.sel);
        check("busy", bus.busy, e.busy);
        check("data_out", bus.Data_out, e.dout);
        check("gnt_onehot0", $onehot0(bus.gnt), 1);
        check("busy_eq_or_gnt", bus.busy, |bus.gnt);
        if (reset) begin
          for (int i = 0; i < 4; i++) waitc[i] = 0;
        end else begin
          if (bus.gnt != 4'b0 && bus.gnt != prev_gnt) begin
            check("gnt_to_sampled_req", |(bus.gnt & bus.req), 1);
            for (int i = 0; i < 4; i++) begin
              if (bus.gnt[i]) waitc[i] = 0;
              else if (bus.req[i]) begin
                waitc[i]++;
                check("wait_le_3_tenures", waitc[i] > 3, 0);
              end
            end
          end
          for (int i = 0; i < 4; i++) if (!bus.req[i]) waitc[i] = 0;
        end
      end
      prev_gnt = bus.gnt;
    end
  end

  initial begin
    logic [3:0] r;
    reset = 1'b1;
    bus.req = 4'b0;
    bus.data1 = '0; bus.data2 = '0; bus.data3 = '0; bus.data4 = '0;
    for (int i = 0; i < 4; i++) dv[i] = '0;

    // Reset with no requests.
    repeat (10) step(4'b0000, 1'b1);

    // All request; each owner drops after one grant cycle, 0 returns.
    step(4'b1111, 1'b0);
    step(4'b1110, 1'b0);
    step(4'b1100, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);

    // Single requester 2 with a fixed word, then idle keeps the select.
    keep_data = 1'b1;
    dv[2] = 12'hABC;
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    repeat (3) step(4'b0000, 1'b0);
    keep_data = 1'b0;

    // Owner 1 holds while requester 3 waits.
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    repeat (20) step(4'b1010, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);

    // Reset mid-tenure, then priority restarts at requester 0.
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    step(4'b1010, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);

    // Random requesters: raise at will, owner drops at will, rare early drops.
    r = 4'b0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!r[i]) begin
          if ($urandom_range(0, 9) < 3) r[i] = 1'b1;
        end else if (i == m_owner) begin
          if ($urandom_range(0, 9) < 4) r[i] = 1'b0;
        end else if ($urandom_range(0, 99) == 0) begin
          r[i] = 1'b0;
        end
      end
      step(r, ($urandom_range(0, 999) == 0));
    end
    step(4'b0000, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
